// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction-fetch front end with a PC generator and an
// N-entry prefetch queue in front of a 1-cycle-latency synchronous RAM.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   fetch_en                      permit new read issue
//   pc_sel                        00 seq, 01 imm redirect, 10 alu redirect, 11 hold
//   imm_addr, alu_addr            redirect targets (word addresses)
//   mem_rd, mem_rd_addr           RAM read request
//   mem_rd_data                   RAM read data, one cycle after mem_rd
//   instr_valid/ready/data/pc     queue head handshake to decode
//   fifo_level                    current queue occupancy
//   cntlr_wr/waddr/wr_data        controller program-load write
//   mem_wr/mem_wr_addr/wr_data    RAM write port (passthrough)
module fetch_prefetch #(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fetch_en,
  input  logic [1:0]                        pc_sel,
  input  logic [ADDR_WIDTH-1:0]             imm_addr,
  input  logic [ADDR_WIDTH-1:0]             alu_addr,
  output logic                              mem_rd,
  output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]             mem_rd_data,
  output logic                              instr_valid,
  input  logic                              instr_ready,
  output logic [DATA_WIDTH-1:0]             instr_data,
  output logic [ADDR_WIDTH-1:0]             instr_pc,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  input  logic                              cntlr_wr,
  input  logic [ADDR_WIDTH-1:0]             cntlr_waddr,
  input  logic [DATA_WIDTH-1:0]             cntlr_wr_data,
  output logic                              mem_wr,
  output logic [ADDR_WIDTH-1:0]             mem_wr_addr,
  output logic [DATA_WIDTH-1:0]             mem_wr_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;

  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;

  logic redirect;
  logic issue;
  logic push;
  logic pop;

  assign redirect = (pc_sel == 2'b01) || (pc_sel == 2'b10);

  // Space check counts the in-flight read but not a same-cycle pop, so the
  // queue can never overflow when the return lands.
  assign issue = ~rst & fetch_en & (pc_sel == 2'b00) &
                 ((level + LVL_W'(inflight)) < LVL_W'(FIFO_DEPTH));

  // A redirect kills the returning read and ignores any pop that cycle.
  assign push = inflight & ~redirect;
  assign pop  = (level != '0) & instr_ready & ~redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= ADDR_WIDTH'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
    end else begin
      if (redirect) begin
        pc     <= (pc_sel == 2'b01) ? imm_addr : alu_addr;
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (issue) pc <= pc + 1'b1;
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        level <= level + LVL_W'(push) - LVL_W'(pop);
      end
      inflight <= issue;
      if (issue) inflight_pc <= pc;
    end
  end

  // Storage needs no reset: the head outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_data[wr_ptr] <= mem_rd_data;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

  always_comb begin
    mem_rd      = issue;
    mem_rd_addr = pc;
    instr_valid = (level != '0);
    instr_data  = '0;
    instr_pc    = '0;
    if (level != '0) begin
      instr_data = q_data[rd_ptr];
      instr_pc   = q_pc[rd_ptr];
    end
    fifo_level  = level;
    mem_wr      = cntlr_wr;
    mem_wr_addr = cntlr_waddr;
    mem_wr_data = cntlr_wr_data;
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NW    = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst, fetch_en, instr_ready, cntlr_wr;
  logic [1:0]    pc_sel;
  logic [AW-1:0] imm_addr, alu_addr, cntlr_waddr;
  logic [DW-1:0] cntlr_wr_data, mem_rd_data;
  logic          mem_rd, instr_valid, mem_wr;
  logic [AW-1:0] mem_rd_addr, instr_pc, mem_wr_addr;
  logic [DW-1:0] instr_data, mem_wr_data;
  logic [2:0]    fifo_level;

  always #5 clk = ~clk;

  fetch_prefetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_sel(pc_sel),
    .imm_addr(imm_addr), .alu_addr(alu_addr),
    .mem_rd(mem_rd), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .fifo_level(fifo_level),
    .cntlr_wr(cntlr_wr), .cntlr_waddr(cntlr_waddr), .cntlr_wr_data(cntlr_wr_data),
    .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  // Instruction RAM: synchronous read, 1-cycle latency.
  logic [DW-1:0] ram [NW];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_wr_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= ram[mem_rd_addr];
  end

  // Reference model: a queue of expected {pc, data} pairs plus one pending read.
  typedef struct { int unsigned pc; logic [DW-1:0] data; } ent_t;
  ent_t        mq[$];
  int unsigned mpc;
  bit          pend;
  ent_t        pend_e;

  int unsigned dq_pc[$];
  logic [DW-1:0] dq_data[$];
  int          total = 0;
  int          bad   = 0;
  int          issued = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    bit redir, iss, pp;
    ent_t h;
    #1;
    redir = (pc_sel == 2'b01) || (pc_sel == 2'b10);
    iss = !rst && fetch_en && pc_sel == 2'b00 && (mq.size() + int'(pend) < DEPTH);
    chk("mem_rd", 64'(mem_rd), 64'(iss));
    chk("mem_wr", 64'(mem_wr), 64'(cntlr_wr));
    if (cntlr_wr) begin
      chk("mem_wr_addr", 64'(mem_wr_addr), 64'(cntlr_waddr));
      chk("mem_wr_data", 64'(mem_wr_data), 64'(cntlr_wr_data));
    end
    if (!rst) begin
      if (iss) chk("mem_rd_addr", 64'(mem_rd_addr), 64'(mpc));
      chk("instr_valid", 64'(instr_valid), 64'(mq.size() > 0));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      if (mq.size() > 0) begin
        h = mq[0];
      end else begin
        h.pc = 0; h.data = '0;
      end
      chk("instr_pc", 64'(instr_pc), 64'(h.pc));
      chk("instr_data", 64'(instr_data), 64'(h.data));
      if (instr_valid === 1'b1 && instr_ready && !redir) begin
        dq_pc.push_back(int'(instr_pc));
        dq_data.push_back(instr_data);
      end
    end
    if (mem_rd === 1'b1) issued++;
    if (rst) begin
      mq.delete(); pend = 0; mpc = 0;
    end else begin
      pp = mq.size() > 0 && instr_ready && !redir;
      if (redir) begin
        mq.delete();
        mpc = (pc_sel == 2'b01) ? int'(imm_addr) : int'(alu_addr);
      end else begin
        if (pp) void'(mq.pop_front());
        if (pend) mq.push_back(pend_e);
      end
      if (iss) begin
        pend_e.pc = mpc; pend_e.data = ram[mpc];
        mpc = (mpc + 1) % NW;
      end
      pend = iss;
    end
    @(negedge clk);
  endtask

  task automatic run_until(input int n, input int budget);
    int c = 0;
    while (dq_pc.size() < n && c < budget) begin cycle(); c++; end
    if (dq_pc.size() < n) chk("timeout", 64'(dq_pc.size()), 64'(n));
  endtask

  task automatic idle_inputs();
    fetch_en = 0; pc_sel = 0; imm_addr = 0; alu_addr = 0; instr_ready = 0;
    cntlr_wr = 0; cntlr_waddr = 0; cntlr_wr_data = 0;
  endtask

  typedef struct {
    logic          rd; logic [AW-1:0] addr; logic valid;
    logic [AW-1:0] pc; logic [DW-1:0] data;
  } vec_t;
  vec_t tbl[6];

  initial begin
    for (int k = 0; k < 6; k++) begin
      tbl[k].rd    = 1'b1;
      tbl[k].addr  = AW'(k);
      tbl[k].valid = (k >= 2);
      tbl[k].pc    = (k >= 2) ? AW'(k - 2) : '0;
      tbl[k].data  = (k >= 2) ? DW'(32'h1000 + k - 2) : '0;
    end
    rst = 1; idle_inputs();
    mq.delete(); pend = 0; mpc = 0;
    @(negedge clk);

    // Program load through the controller path while in reset.
    for (int i = 0; i < NW; i++) begin
      cntlr_wr = 1; cntlr_waddr = AW'(i); cntlr_wr_data = DW'(32'h1000 + i);
      cycle();
    end
    cntlr_wr = 0;
    cycle();

    // Sequential fetch after reset release.
    rst = 0; fetch_en = 1; instr_ready = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("tbl_rd", 64'(mem_rd), 64'(tbl[k].rd));
      chk("tbl_addr", 64'(mem_rd_addr), 64'(tbl[k].addr));
      chk("tbl_valid", 64'(instr_valid), 64'(tbl[k].valid));
      chk("tbl_pc", 64'(instr_pc), 64'(tbl[k].pc));
      chk("tbl_data", 64'(instr_data), 64'(tbl[k].data));
      cycle();
    end

    // Stall: exactly DEPTH reads, queue full, then in-order drain and resume.
    rst = 1; cycle(); rst = 0;
    instr_ready = 0; issued = 0; dq_pc.delete(); dq_data.delete();
    for (int k = 0; k < 10; k++) cycle();
    #1;
    chk("stall_issued", 64'(issued), 64'(DEPTH));
    chk("stall_level", 64'(fifo_level), 64'(DEPTH));
    chk("stall_mem_rd", 64'(mem_rd), 64'(0));
    instr_ready = 1;
    run_until(5, 20);
    for (int k = 0; k < 5 && k < dq_pc.size(); k++)
      chk("stall_order", 64'(dq_pc[k]), 64'(k));

    // Redirect with 3 queued entries and a read in flight.
    rst = 1; cycle(); rst = 0; instr_ready = 0;
    for (int k = 0; k < 20 && !(mq.size() == 3 && pend); k++) cycle();
    chk("pre_redirect_level", 64'(fifo_level), 64'(3));
    pc_sel = 2'b01; imm_addr = AW'(11'h200); instr_ready = 1;
    cycle();
    pc_sel = 2'b00; dq_pc.delete(); dq_data.delete();
    for (int k = 1; k <= 3; k++) begin
      #1;
      if (k == 1) begin
        chk("redir_addr", 64'(mem_rd_addr), 64'(11'h200));
        chk("redir_level", 64'(fifo_level), 64'(0));
      end
      chk("redir_valid", 64'(instr_valid), 64'(k == 3));
      if (k == 3) chk("redir_first_pc", 64'(instr_pc), 64'(11'h200));
      cycle();
    end
    for (int k = 0; k < 6; k++) cycle();
    for (int k = 0; k < dq_pc.size(); k++)
      chk("redir_no_stale", 64'(dq_pc[k]), 64'(32'h200 + k));

    // PC wrap at the top of the address space.
    pc_sel = 2'b10; alu_addr = AW'(11'h7FE); cycle();
    pc_sel = 2'b00; dq_pc.delete(); dq_data.delete();
    run_until(4, 20);
    if (dq_pc.size() >= 4) begin
      chk("wrap0", 64'(dq_pc[0]), 64'(11'h7FE));
      chk("wrap1", 64'(dq_pc[1]), 64'(11'h7FF));
      chk("wrap2", 64'(dq_pc[2]), 64'(0));
      chk("wrap3", 64'(dq_pc[3]), 64'(1));
    end

    // Hold, then ALU redirect in a cycle where a pop is requested.
    for (int k = 0; k < 3; k++) cycle();
    pc_sel = 2'b11; instr_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1; chk("hold_no_issue", 64'(mem_rd), 64'(0));
      cycle();
    end
    chk("hold_level", 64'(fifo_level), 64'(2));
    pc_sel = 2'b10; alu_addr = AW'(11'h055); instr_ready = 1;
    cycle();
    pc_sel = 2'b00; dq_pc.delete(); dq_data.delete();
    run_until(1, 10);
    if (dq_pc.size() >= 1) chk("alu_redir_pc", 64'(dq_pc[0]), 64'(11'h055));

    // Program patch with fetch disabled, then redirect and refetch.
    fetch_en = 0;
    for (int k = 0; k < 6; k++) cycle();
    cntlr_wr = 1; cntlr_waddr = AW'(11'h010); cntlr_wr_data = 32'hDEADBEEF;
    #1;
    chk("wr_pass_en", 64'(mem_wr), 64'(1));
    chk("wr_pass_addr", 64'(mem_wr_addr), 64'(11'h010));
    chk("wr_pass_data", 64'(mem_wr_data), 64'(32'hDEADBEEF));
    cycle();
    cntlr_wr = 0;
    pc_sel = 2'b01; imm_addr = AW'(11'h010); cycle();
    pc_sel = 2'b00; fetch_en = 1; dq_pc.delete(); dq_data.delete();
    run_until(1, 10);
    if (dq_pc.size() >= 1) begin
      chk("patch_pc", 64'(dq_pc[0]), 64'(11'h010));
      chk("patch_data", 64'(dq_data[0]), 64'(32'hDEADBEEF));
    end

    // Reset mid-stream.
    for (int k = 0; k < 4; k++) cycle();
    rst = 1; cycle(); rst = 0;
    #1;
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_valid", 64'(instr_valid), 64'(0));
    chk("rst_addr", 64'(mem_rd_addr), 64'(0));
    dq_pc.delete(); dq_data.delete();
    run_until(1, 10);
    if (dq_pc.size() >= 1) chk("rst_restart_pc", 64'(dq_pc[0]), 64'(0));

    // Randomised traffic against the model.
    for (int k = 0; k < 800; k++) begin
      int unsigned r;
      rst = ($urandom_range(0, 99) == 0);
      fetch_en = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      pc_sel = (r < 7) ? 2'b00 : (r == 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      imm_addr = AW'($urandom); alu_addr = AW'($urandom);
      instr_ready = ($urandom_range(0, 9) < 7);
      cntlr_wr = !fetch_en && $urandom_range(0, 1) == 1;
      cntlr_waddr = AW'($urandom); cntlr_wr_data = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
